// File: rtl/ibex_mult_pext_seq_if.sv
// rtl/ibex_mult_pext_seq_if.sv - request/result bundle between P-ext decode and the 32x32 multiply sequencer
//
// Purpose: groups the request (operands, decoded controls, start/kill) and the
// registered result signals of ibex_mult_pext_seq.
// Ports (signals):
//   start_i, kill_i                      request / abort
//   cycle_count_i[1:0]                   01 product only, 11 product plus accumulate
//   signed_a_i, signed_b_i               operand signedness
//   hi_sel_i, round_i, sub_i             word select, rounding, accumulate by subtraction
//   op_a_i, op_b_i, acc_i [31:0]         operands and rd value
//   ready_o, valid_o                     idle indication, one-cycle result strobe
//   res_o[31:0], prod_o[63:0], ov_o      result, raw product, accumulate overflow
// Modports: master drives the request (decode side), slave is the sequencer.

interface ibex_mult_pext_seq_if;
  logic        start_i;
  logic [1:0]  cycle_count_i;
  logic        signed_a_i;
  logic        signed_b_i;
  logic        hi_sel_i;
  logic        round_i;
  logic        sub_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] acc_i;
  logic        kill_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] res_o;
  logic [63:0] prod_o;
  logic        ov_o;

  modport master (
    output start_i, cycle_count_i, signed_a_i, signed_b_i, hi_sel_i, round_i, sub_i,
           op_a_i, op_b_i, acc_i, kill_i,
    input  ready_o, valid_o, res_o, prod_o, ov_o
  );

  modport slave (
    input  start_i, cycle_count_i, signed_a_i, signed_b_i, hi_sel_i, round_i, sub_i,
           op_a_i, op_b_i, acc_i, kill_i,
    output ready_o, valid_o, res_o, prod_o, ov_o
  );
endinterface

// File: rtl/ibex_mult_pext_seq.sv
// rtl/ibex_mult_pext_seq.sv - multi-cycle 32x32 P-ext multiply sequencer with optional accumulate
//
// Purpose: builds a 64-bit product from two 33x17 partial products (low half of
// op_b in the accept cycle, high half in HI), optionally adds/subtracts the
// selected word to/from rd in ACC, and presents a registered result in DONE.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     ibex_mult_pext_seq_if.slave (request in, registered result out)

module ibex_mult_pext_seq (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ibex_mult_pext_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;

  // captured request
  logic [31:0] a_q;
  logic [15:0] b_hi_q;
  logic [31:0] acc_q;
  logic        signed_a_q, signed_b_q, hi_sel_q, round_q, sub_q, accum_q;
  logic [63:0] partial_q;

  // results
  logic [63:0] prod_q;
  logic [31:0] res_q;
  logic        ov_q;

  logic        accept;
  logic        ready, valid;

  // cycle_count bit 0 set marks a supported encoding (01 / 11); bit 1 selects accumulate
  assign accept = (state_q == IDLE) && bus.start_i && bus.cycle_count_i[0];

  // ---------------- LO partial product (accept cycle) ----------------
  // Operands are widened to 50 bits so the multiply is 50x50 -> 50 with no
  // truncation of the true 33x17 signed product.
  logic [32:0]        a_ext_lo;
  logic signed [49:0] a50_lo, b50_lo, pp_lo;

  assign a_ext_lo = {bus.signed_a_i & bus.op_a_i[31], bus.op_a_i};
  assign a50_lo   = {{17{a_ext_lo[32]}}, a_ext_lo};
  assign b50_lo   = {34'd0, bus.op_b_i[15:0]};
  assign pp_lo    = a50_lo * b50_lo;

  // ---------------- HI partial product and full product ----------------
  logic [32:0]        a_ext_hi;
  logic [16:0]        b_ext_hi;
  logic signed [49:0] a50_hi, b50_hi, pp_hi;
  logic [63:0]        pp_hi_64;
  logic [63:0]        prod_d;

  assign a_ext_hi = {signed_a_q & a_q[31], a_q};
  assign b_ext_hi = {signed_b_q & b_hi_q[15], b_hi_q};
  assign a50_hi   = {{17{a_ext_hi[32]}}, a_ext_hi};
  assign b50_hi   = {{33{b_ext_hi[16]}}, b_ext_hi};
  assign pp_hi    = a50_hi * b50_hi;
  assign pp_hi_64 = {{14{pp_hi[49]}}, pp_hi};
  assign prod_d   = partial_q + (pp_hi_64 << 16);

  // Word selection; rounding only affects the high word.
  function automatic logic [31:0] select_word(input logic [63:0] p, input logic hs, input logic rd);
    logic [63:0] r;
    r = p + (rd ? 64'h0000_0000_8000_0000 : 64'h0);
    return hs ? r[63:32] : p[31:0];
  endfunction

  logic [31:0] sel_hi, sel_acc, sum;
  logic        ov_d;

  assign sel_hi  = select_word(prod_d, hi_sel_q, round_q);
  assign sel_acc = select_word(prod_q, hi_sel_q, round_q);
  assign sum     = sub_q ? (acc_q - sel_acc) : (acc_q + sel_acc);

  // Signed overflow: add overflows when operand signs agree and the result
  // sign differs; subtract when operand signs differ and the result sign
  // differs from the minuend. Reported only for high-word (K-op) accumulates.
  assign ov_d = hi_sel_q
              & (sub_q ? (acc_q[31] != sel_acc[31]) : (acc_q[31] == sel_acc[31]))
              & (sum[31] != acc_q[31]);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HI;
      HI:      if (bus.kill_i) state_d = IDLE;
               else            state_d = accum_q ? ACC : DONE;
      ACC:     state_d = bus.kill_i ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      DONE:    valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q        <= '0;
      b_hi_q     <= '0;
      acc_q      <= '0;
      signed_a_q <= 1'b0;
      signed_b_q <= 1'b0;
      hi_sel_q   <= 1'b0;
      round_q    <= 1'b0;
      sub_q      <= 1'b0;
      accum_q    <= 1'b0;
      partial_q  <= '0;
      prod_q     <= '0;
      res_q      <= '0;
      ov_q       <= 1'b0;
    end else begin
      if (accept) begin
        a_q        <= bus.op_a_i;
        b_hi_q     <= bus.op_b_i[31:16];
        acc_q      <= bus.acc_i;
        signed_a_q <= bus.signed_a_i;
        signed_b_q <= bus.signed_b_i;
        hi_sel_q   <= bus.hi_sel_i;
        round_q    <= bus.round_i;
        sub_q      <= bus.sub_i;
        accum_q    <= bus.cycle_count_i[1];
        partial_q  <= {{14{pp_lo[49]}}, pp_lo};
      end
      // a killed op leaves the visible result registers untouched
      if (state_q == HI && !bus.kill_i) begin
        prod_q <= prod_d;
        if (!accum_q) begin
          res_q <= sel_hi;
          ov_q  <= 1'b0;
        end
      end
      if (state_q == ACC && !bus.kill_i) begin
        res_q <= sum;
        ov_q  <= ov_d;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid;
  assign bus.res_o   = res_q;
  assign bus.prod_o  = prod_q;
  assign bus.ov_o    = ov_q;

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// tb/tb_ibex_mult_pext_seq.sv - scoreboard testbench for ibex_mult_pext_seq

module tb_ibex_mult_pext_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_mult_pext_seq_if bus ();

  ibex_mult_pext_seq dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [63:0] prod;
    logic        ov;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   edges = 0;

  always @(posedge clk) edges++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: full-width product of the extended operands, then word select
  // and accumulate with wide signed arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                                 input logic sa, input logic sgb, input logic hs, input logic rd,
                                 input logic sub, input logic [1:0] cc);
    exp_t        e;
    logic [63:0] av, bv, p, pr;
    logic [31:0] sel;
    longint      s;
    av = sa  ? {{32{a[31]}}, a} : {32'h0, a};
    bv = sgb ? {{32{b[31]}}, b} : {32'h0, b};
    p  = av * bv;
    pr = p + (rd ? 64'd2147483648 : 64'd0);
    sel = hs ? pr[63:32] : p[31:0];
    e.prod = p;
    e.edge_no = 0;
    if (cc == 2'b11) begin
      if (sub) s = longint'($signed(acc)) - longint'($signed(sel));
      else     s = longint'($signed(acc)) + longint'($signed(sel));
      e.res = s[31:0];
      e.ov  = hs && (s > 64'sd2147483647 || s < -64'sd2147483648);
    end else begin
      e.res = sel;
      e.ov  = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every result strobe with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.valid_o) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual=1 required=0");
        end else begin
          e = sb.pop_front();
          check("res", 64'(bus.res_o), 64'(e.res));
          check("prod", bus.prod_o, e.prod);
          check("ov", 64'(bus.ov_o), 64'(e.ov));
          check("latency_edge", 64'(edges), 64'(e.edge_no));
          check("ready_in_done", 64'(bus.ready_o), 64'd0);
        end
      end
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Entered at a negedge with ready_o=1; returns at a negedge with ready_o=1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                       input logic sa, input logic sgb, input logic hs, input logic rd,
                       input logic sub, input logic [1:0] cc,
                       input bit do_kill, input bit kill_done, input bit kill_with_start,
                       input bit do_reset);
    exp_t        e;
    logic [31:0] res_before;
    logic [63:0] prod_before;
    int          acc_edge;
    int          lat;
    res_before  = bus.res_o;
    prod_before = bus.prod_o;
    lat = (cc == 2'b11) ? 2 : 1;
    bus.op_a_i = a;  bus.op_b_i = b;  bus.acc_i = acc;
    bus.signed_a_i = sa; bus.signed_b_i = sgb; bus.hi_sel_i = hs;
    bus.round_i = rd; bus.sub_i = sub; bus.cycle_count_i = cc;
    bus.start_i = 1'b1;
    bus.kill_i  = kill_with_start;
    @(posedge clk);
    #1;
    acc_edge = edges;
    if (!cc[0]) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.kill_i  = 1'b0;
      check("ignored_cc_ready", 64'(bus.ready_o), 64'd1);
      return;
    end
    if (!do_kill && !do_reset) begin
      e = model(a, b, acc, sa, sgb, hs, rd, sub, cc);
      e.edge_no = acc_edge + lat;
      sb.push_back(e);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        check("ready_return_cycle", 64'(k), do_kill ? 64'd2 : 64'(lat + 2));
        if (do_kill) begin
          check("kill_res_hold", 64'(bus.res_o), 64'(res_before));
          check("kill_prod_hold", bus.prod_o, prod_before);
        end
        return;
      end
      // busy: keep requesting with unrelated operands, which must be ignored
      bus.start_i = 1'b1;
      bus.op_a_i = $urandom; bus.op_b_i = $urandom; bus.acc_i = $urandom;
      bus.signed_a_i = 1'($urandom); bus.signed_b_i = 1'($urandom);
      bus.sub_i = 1'($urandom); bus.cycle_count_i = 2'b01;
      bus.kill_i = (do_kill && k == 1) || (kill_done && k == lat + 1);
      if (do_reset && k == 2) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_res", 64'(bus.res_o), 64'd0);
        check("rst_prod", bus.prod_o, 64'd0);
        check("rst_ov", 64'(bus.ov_o), 64'd0);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ready_timeout actual=0 required=1");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cc;
    logic       hs;
    bus.start_i = 1'b0; bus.kill_i = 1'b0; bus.cycle_count_i = 2'b00;
    bus.signed_a_i = 1'b0; bus.signed_b_i = 1'b0; bus.hi_sel_i = 1'b0;
    bus.round_i = 1'b0; bus.sub_i = 1'b0;
    bus.op_a_i = '0; bus.op_b_i = '0; bus.acc_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd1);
    check("reset_valid", 64'(bus.valid_o), 64'd0);
    check("reset_res", 64'(bus.res_o), 64'd0);
    check("reset_prod", bus.prod_o, 64'd0);
    check("reset_ov", 64'(bus.ov_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //     a             b             acc           sa sb hs rd sb cc     kil kd  kws rst
    issue(32'd3,        32'd5,        32'd0,        0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    issue(32'h8000_0000, 32'h8000_0000, 32'd0,      1, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0);
    issue(32'd1,        32'h8000_0000, 32'd0,       1, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0);
    issue(32'd1,        32'h8000_0000, 32'd0,       1, 1, 1, 1, 0, 2'b01, 0, 0, 0, 0);
    issue(32'd7,        32'd6,        32'd100,      0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    issue(32'd7,        32'd6,        32'd100,      0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0);
    issue(32'h4000_0000, 32'd4,       32'h7FFF_FFFF, 1, 1, 1, 0, 0, 2'b11, 0, 0, 0, 0);
    issue(32'd3,        32'd5,        32'd0,        0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    issue(32'd3,        32'd5,        32'd0,        0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 32'd0,      1, 0, 1, 0, 0, 2'b01, 1, 0, 0, 0);
    issue(32'd9,        32'd9,        32'd1,        0, 0, 0, 0, 0, 2'b11, 0, 0, 1, 0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,      1, 1, 1, 1, 1, 2'b11, 0, 1, 0, 0);
    issue(32'h0BAD_CAFE, 32'h1234_5678, 32'd77,     1, 1, 1, 0, 0, 2'b11, 0, 0, 0, 1);
    check("after_reset_res", 64'(bus.res_o), 64'd0);

    for (int i = 0; i < 120; i++) begin
      cc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) cc[0] = 1'b1;
      hs = 1'($urandom);
      issue(rand_operand(), rand_operand(), rand_operand(),
            1'($urandom), 1'($urandom), hs, hs & 1'($urandom), 1'($urandom), cc,
            cc[0] && ($urandom_range(0, 9) == 0),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            1'b0);
    end

    repeat (6) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_mult_pext_seq.md
# ibex_mult_pext_seq

Multi-cycle sequencer and accumulator for the 32x32 P-extension multiply ops (SMMUL[u], KWMMUL[u], KMMAC[u], KMMSB[u], MADDR32, MSUBR32). It sits directly downstream of the P-ext multiplier decode. It consumes the decoded cycle count, accumulate, subtract and rounding controls. It builds the 64-bit product from two 33x17 partial products over consecutive cycles, optionally accumulates into rd, and returns a registered result to the ALU writeback path.

## Interface
Parameters: none.

- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request. Accepted only when ready_o=1.
- cycle_count_i  in  2  decoded cycle count: 2'b01 = product only, 2'b11 = product plus accumulate. 2'b00 and 2'b10 are not handled by this block.
- signed_a_i, signed_b_i  in  1 each  operand signedness.
- hi_sel_i  in  1  use product[63:32] (1) or product[31:0] (0).
- round_i  in  1  add 2^31 to the product before selection (u variants). Valid only with hi_sel_i=1.
- sub_i  in  1  accumulate by subtraction (KMMSB, MSUBR32).
- op_a_i, op_b_i, acc_i  in  32 each  operands and rd value.
- kill_i  in  1  abort the current operation.
- ready_o  out  1  idle and able to accept.
- valid_o  out  1  one-cycle result strobe.
- res_o  out  32  result.
- prod_o  out  64  raw (unrounded) product register.
- ov_o  out  1  signed 32-bit overflow of the accumulate. Valid with valid_o.

## Operation
- States: IDLE, HI, ACC, DONE.
- Control capture: in IDLE, start_i=1 with cycle_count_i in {01,11} captures all operands and controls into registers. start_i with cycle_count_i in {00,10} is ignored: the block stays in IDLE and no valid_o is produced.
- Extension: a_ext is op_a extended to 33 bits, sign- or zero-extended per signed_a.
- LO cycle (the accept cycle):
  - pp = a_ext × {1'b0, b[15:0]}.
  - pp is stored in a 64-bit partial register, sign-extended per signed_a.
- HI state:
  - b_hi is b[31:16] extended to 17 bits per signed_b.
  - prod = partial + ((a_ext × b_hi) << 16), computed mod 2^64 and registered in prod_o.
  - Next state: cycle_count=01 goes to DONE. cycle_count=11 goes to ACC.
- Selection: sel = hi_sel ? (prod + (round ? 2^31 : 0))[63:32] : prod[31:0].
- ACC state:
  - sum = acc ± sel, computed mod 2^32.
  - ov_o = signed overflow of that 32-bit add or sub. ov_o is forced to 0 when hi_sel=0.
  - No saturation is applied here; downstream K-op saturation uses ov_o.
- Result register:
  - cycle_count=01: sel is written to the result register in HI.
  - cycle_count=11: sum is written to the result register in ACC.
- DONE state: valid_o=1 for exactly one cycle, then IDLE.
- Kill:
  - kill_i in HI or ACC forces IDLE next cycle. No valid_o is produced.
  - res_o and prod_o keep their last contents.
  - kill_i in IDLE is a no-op, even when asserted together with start_i; start wins.
- kill_i in DONE does not suppress valid_o.
- Operands may change after acceptance without affecting the result.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - ready_o=1, valid_o=0, res_o=0, prod_o=0, ov_o=0.
  - The partial register and the captured controls are cleared.
- ready_o=1 only in IDLE. It is 0 from the cycle after acceptance until valid_o has been seen, and returns high in the cycle after valid_o.
- Latency, for a start accepted at edge T:
  - cycle_count=01: valid_o high in cycle T+2.
  - cycle_count=11: valid_o high in cycle T+3.
- Throughput: at most one op every 3 cycles (cycle_count=01) or every 4 cycles (cycle_count=11).
- All outputs are registered. No combinational path from inputs to outputs except none; ready_o is decoded from state.
- res_o, prod_o and ov_o hold their value until the next completed op.

## Test plan
- Unsigned, product only: a=3, b=5, cycle_count=01, hi_sel=0 → valid_o at T+2, res_o=15, prod_o=15.
- Signed high word: a=b=0x8000_0000, signed, cycle_count=01, hi_sel=1 → prod_o=0x4000_0000_0000_0000, res_o=0x4000_0000.
- Rounding, with a=1, b=0x8000_0000, signed, hi_sel=1:
  - round=0 → res_o=0xFFFF_FFFF.
  - round=1 → res_o=0x0000_0000.
  - prod_o=0xFFFF_FFFF_8000_0000 in both cases.
- Accumulate, with a=7, b=6, acc=100, cycle_count=11, hi_sel=0:
  - sub=0 → res_o=142 at T+3.
  - sub=1 → res_o=58.
  - ov_o=0 in both cases.
- Overflow: a=0x4000_0000, b=4, signed, hi_sel=1, acc=0x7FFF_FFFF, cycle_count=11 → res_o=0x8000_0000, ov_o=1.
- Control corner cases:
  - start_i with cycle_count=00 → no valid_o, ready_o stays 1.
  - kill_i in cycle T+1 → no valid_o, ready_o=1 at T+2.
  - start_i while busy → ignored.
  - rst_ni low mid-ACC → all outputs zero immediately.
